// File: rtl/f2f_pkg.sv
// Shared definitions for the pipelined float-to-fixed converter: rounding
// modes, operand classes and exponent-width helpers.
package f2f_pkg;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    DENORM,
    INF,
    NAN
  } f2f_class_e;

  function automatic int exp_bias(input int exponent_bits);
    return (1 << (exponent_bits - 1)) - 1;
  endfunction

  // Signed width that holds any unbiased exponent, including 1-bias for denormals.
  function automatic int unbiased_width(input int exponent_bits);
    return exponent_bits + 2;
  endfunction

endpackage

// File: rtl/f2f_round_sat.sv
// Final stage of the converter: round the aligned magnitude, apply the sign
// and clamp to the two's complement range, raising overflow or exception.
module f2f_round_sat
  import f2f_pkg::*;
#(
  parameter int FIXEDSIZE = 32
) (
  input  logic                 sign,
  input  logic [FIXEDSIZE:0]   mag,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic                 pre_ovf,
  input  logic                 exc,
  input  logic                 round_mode,
  output logic [FIXEDSIZE-1:0] fixed,
  output logic                 overflow,
  output logic                 exception
);

  localparam logic [FIXEDSIZE-1:0] MAX_VAL = {1'b0, {(FIXEDSIZE-1){1'b1}}};
  localparam logic [FIXEDSIZE-1:0] MIN_VAL = {1'b1, {(FIXEDSIZE-1){1'b0}}};
  // Magnitude limits: max for positive results, |min| = max+1 for negative ones.
  localparam logic [FIXEDSIZE+1:0] POS_LIMIT = {2'b00, MAX_VAL};
  localparam logic [FIXEDSIZE+1:0] NEG_LIMIT = {2'b00, MIN_VAL};

  logic                 inc;
  logic [FIXEDSIZE+1:0] rounded;

  always_comb begin
    inc       = (round_mode == RND_RNE) && guard && (sticky || mag[0]);
    rounded   = {1'b0, mag} + {{(FIXEDSIZE+1){1'b0}}, inc};
    fixed     = '0;
    overflow  = 1'b0;
    exception = 1'b0;
    if (exc) begin
      exception = 1'b1;
    end else if (pre_ovf || (!sign && rounded > POS_LIMIT) || (sign && rounded > NEG_LIMIT)) begin
      overflow = 1'b1;
      fixed    = sign ? MIN_VAL : MAX_VAL;
    end else if (sign) begin
      fixed = -rounded[FIXEDSIZE-1:0];
    end else begin
      fixed = rounded[FIXEDSIZE-1:0];
    end
  end

endmodule

// File: rtl/float2fixed_pipe.sv
// Three-stage float-to-fixed converter (unpack, align, round/saturate) with
// a per-transaction radix point and elastic valid/ready flow control.
module float2fixed_pipe
  import f2f_pkg::*;
#(
  parameter int FLOATSIZE      = 32,
  parameter int EXPONENTBITS   = 8,
  parameter int MANTISSABITS   = 23,
  parameter int FIXEDSIZE      = 32,
  parameter int RADIXPOINTSIZE = 6
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [FLOATSIZE-1:0]      InFloat,
  input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
  input  logic                      InRoundMode,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [FIXEDSIZE-1:0]      OutFixed,
  output logic                      OutOverflow,
  output logic                      OutException
);

  localparam int BIAS = exp_bias(EXPONENTBITS);
  localparam int EW   = unbiased_width(EXPONENTBITS);
  localparam int SW   = MANTISSABITS + 1;
  localparam int MW   = FIXEDSIZE + 1;

  // Handshake: a beat moves on a rising edge where valid && ready; valid never
  // waits on ready, and a stalled output holds its data until accepted.
  logic s1_valid, s2_valid;
  logic s1_free, s2_free, s3_free;

  assign s3_free = !OutValid || OutReady;
  assign s2_free = !s2_valid || s3_free;
  assign s1_free = !s1_valid || s2_free;
  assign InReady = ResetN && s1_free;

  logic [EXPONENTBITS-1:0] exp_field;
  logic [MANTISSABITS-1:0] man_field;
  logic                    u_sign;
  logic signed [EW-1:0]    u_exp;
  logic [SW-1:0]           u_sig;
  f2f_class_e              u_cls;

  assign exp_field = InFloat[FLOATSIZE-2 -: EXPONENTBITS];
  assign man_field = InFloat[MANTISSABITS-1:0];

  always_comb begin
    u_sign = InFloat[FLOATSIZE-1];
    u_sig  = {1'b1, man_field};
    u_exp  = $signed({2'b00, exp_field}) - $signed(EW'(BIAS));
    u_cls  = NORM;
    if (exp_field == '0) begin
      u_sig = {1'b0, man_field};
      u_exp = $signed(EW'(1 - BIAS));
      u_cls = (man_field == '0) ? ZERO : DENORM;
    end else if (&exp_field) begin
      u_cls = (man_field == '0) ? INF : NAN;
    end
  end

  logic                      s1_sign, s1_mode;
  logic signed [EW-1:0]      s1_exp;
  logic [SW-1:0]             s1_sig;
  f2f_class_e                s1_cls;
  logic [RADIXPOINTSIZE-1:0] s1_radix;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mode  <= RND_TRUNC;
      s1_exp   <= '0;
      s1_sig   <= '0;
      s1_cls   <= ZERO;
      s1_radix <= '0;
    end else if (s1_free) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_sign  <= u_sign;
        s1_mode  <= InRoundMode;
        s1_exp   <= u_exp;
        s1_sig   <= u_sig;
        s1_cls   <= u_cls;
        s1_radix <= InRadixPoint;
      end
    end
  end

  // Alignment: the significand is worth sig * 2^sh LSBs of the result.
  int              sh, rsh;
  logic [SW+MW-1:0] lsh;
  logic [2*SW:0]    rs;
  logic [MW-1:0]    a_mag;
  logic             a_guard, a_sticky, a_ovf, a_exc;

  always_comb begin
    lsh      = '0;
    rs       = '0;
    a_mag    = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    a_ovf    = 1'b0;
    sh       = int'(s1_exp) - MANTISSABITS + int'(s1_radix);
    rsh      = -sh;
    a_exc    = (s1_cls == NAN) || (int'(s1_radix) > FIXEDSIZE - 1);
    if (s1_cls == INF) begin
      a_ovf = 1'b1;
    end else if (s1_cls == NORM || s1_cls == DENORM) begin
      if (sh > MW) begin
        a_ovf = 1'b1;
      end else if (sh >= 0) begin
        lsh   = {{MW{1'b0}}, s1_sig} << sh;
        a_ovf = |lsh[SW+MW-1:MW];
        a_mag = lsh[MW-1:0];
      end else if (rsh > SW + 1) begin
        a_sticky = |s1_sig;
      end else begin
        rs       = {s1_sig, {(SW+1){1'b0}}} >> rsh;
        a_mag    = MW'(rs[2*SW:SW+1]);
        a_guard  = rs[SW];
        a_sticky = |rs[SW-1:0];
      end
    end
  end

  logic          s2_sign, s2_mode, s2_guard, s2_sticky, s2_ovf, s2_exc;
  logic [MW-1:0] s2_mag;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_mode   <= RND_TRUNC;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_exc    <= 1'b0;
      s2_mag    <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s1_sign;
        s2_mode   <= s1_mode;
        s2_guard  <= a_guard;
        s2_sticky <= a_sticky;
        s2_ovf    <= a_ovf;
        s2_exc    <= a_exc;
        s2_mag    <= a_mag;
      end
    end
  end

  logic [FIXEDSIZE-1:0] r_fixed;
  logic                 r_ovf, r_exc;

  f2f_round_sat #(.FIXEDSIZE(FIXEDSIZE)) u_round_sat (
    .sign      (s2_sign),
    .mag       (s2_mag),
    .guard     (s2_guard),
    .sticky    (s2_sticky),
    .pre_ovf   (s2_ovf),
    .exc       (s2_exc),
    .round_mode(s2_mode),
    .fixed     (r_fixed),
    .overflow  (r_ovf),
    .exception (r_exc)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      OutValid     <= 1'b0;
      OutFixed     <= '0;
      OutOverflow  <= 1'b0;
      OutException <= 1'b0;
    end else if (s3_free) begin
      OutValid <= s2_valid;
      if (s2_valid) begin
        OutFixed     <= r_fixed;
        OutOverflow  <= r_ovf;
        OutException <= r_exc;
      end
    end
  end

endmodule

// File: tb/tb_float2fixed_pipe.sv
// Scoreboard bench for float2fixed_pipe: directed vectors, backpressure,
// mid-stream reset and random traffic against a real-arithmetic model.
module tb_float2fixed_pipe;

  logic        Clock = 1'b0;
  logic        ResetN, InValid, InReady, InRoundMode;
  logic        OutValid, OutReady, OutOverflow, OutException;
  logic [31:0] InFloat, OutFixed;
  logic [5:0]  InRadixPoint;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          occ      = 0;
  bit          saw_not_ready = 1'b0;
  bit          rand_done = 1'b0;
  logic [33:0] exp_q[$];
  int          lat_q[$];

  float2fixed_pipe dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .InValid     (InValid),
    .InReady     (InReady),
    .InFloat     (InFloat),
    .InRadixPoint(InRadixPoint),
    .InRoundMode (InRoundMode),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutFixed    (OutFixed),
    .OutOverflow (OutOverflow),
    .OutException(OutException)
  );

  // Clock and cycle counter
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  // Reference: exact value * 2^radix, then truncate or round-half-even, then clamp.
  function automatic logic [33:0] model(input logic [31:0] f, input int rp, input bit rne);
    bit     s;
    int     e;
    longint m, ip;
    real    mag, v, fl;
    s = f[31];
    e = int'(f[30:23]);
    m = longint'(f[22:0]);
    if ((e == 255 && m != 0) || rp > 31) return {2'b10, 32'h0};
    if (e == 255) return s ? {2'b01, 32'h80000000} : {2'b01, 32'h7FFFFFFF};
    mag = (e == 0) ? real'(m) * pow2(-149) : real'(m + 8388608) * pow2(e - 150);
    v = mag * pow2(rp);
    if (v >= pow2(40)) begin
      ip = longint'(1) << 40;
    end else begin
      fl = $floor(v);
      ip = longint'(fl);
      if (rne && (((v - fl) > 0.5) || (((v - fl) == 0.5) && ip[0]))) ip++;
    end
    if (s) ip = -ip;
    if (ip > 64'sd2147483647) return {2'b01, 32'h7FFFFFFF};
    if (ip < -64'sd2147483648) return {2'b01, 32'h80000000};
    return {2'b00, ip[31:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    int          sel;
    sel = $urandom_range(0, 15);
    s   = 1'($urandom_range(0, 1));
    m   = 23'($urandom());
    if (sel == 0) e = 8'h00;
    else if (sel == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (sel == 2) e = 8'($urandom_range(0, 255));
    else begin
      e = 8'($urandom_range(87, 161));
      if (sel < 8) m = {m[22:19], 19'h0};
    end
    return {s, e, m};
  endfunction

  // Driver: hold the beat until accepted, then record the expectation.
  task automatic send(input logic [31:0] f, input logic [5:0] rp, input logic rm,
                      input logic [33:0] e, input bit lat);
    int waited = 0;
    InValid      = 1'b1;
    InFloat      = f;
    InRadixPoint = rp;
    InRoundMode  = rm;
    @(negedge Clock);
    while (!InReady && waited < 200) begin
      waited++;
      @(negedge Clock);
    end
    if (!InReady) check("send_timeout", 64'(InReady), 64'd1);
    else begin
      exp_q.push_back(e);
      lat_q.push_back(lat ? cyc + 3 : -1);
    end
    @(posedge Clock);
    #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge Clock);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge Clock);
    #1;
  endtask

  // Monitor/scoreboard: the pipe behaves as a 3-entry FIFO of results.
  always @(negedge Clock) begin
    if (!ResetN) begin
      occ = 0;
    end else begin
      check("in_ready", 64'(InReady), 64'((occ < 3) || OutReady));
      if (!InReady) saw_not_ready = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(OutValid), 64'd0);
      end else if (OutValid) begin
        check("result", 64'({OutException, OutOverflow, OutFixed}), 64'(exp_q[0]));
        if (lat_q[0] >= 0) begin
          check("latency", 64'(cyc), 64'(lat_q[0]));
          lat_q[0] = -1;
        end
        if (OutReady) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
      occ = occ + ((InValid && InReady) ? 1 : 0) - ((OutValid && OutReady) ? 1 : 0);
    end
  end

  localparam int ND = 18;
  logic [31:0] d_f[ND] = '{32'h3FC00000, 32'hC0100000, 32'h37C00000, 32'h37C00000,
                           32'h38200000, 32'h38200000, 32'h47800000, 32'hC7000000,
                           32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F800000,
                           32'h80000000, 32'hBF000000, 32'hBF400000, 32'h3F800000,
                           32'hBF800000, 32'h4EFFFFFF};
  logic [5:0]  d_r[ND] = '{6'd16, 6'd16, 6'd16, 6'd16, 6'd16, 6'd16, 6'd16, 6'd16, 6'd16,
                           6'd16, 6'd16, 6'd40, 6'd16, 6'd0, 6'd0, 6'd31, 6'd31, 6'd0};
  logic        d_m[ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [33:0] d_e[ND] = '{{2'b00, 32'h00018000}, {2'b00, 32'hFFFDC000},
                           {2'b00, 32'h00000002}, {2'b00, 32'h00000001},
                           {2'b00, 32'h00000002}, {2'b00, 32'h00000002},
                           {2'b01, 32'h7FFFFFFF}, {2'b00, 32'h80000000},
                           {2'b01, 32'h7FFFFFFF}, {2'b01, 32'h80000000},
                           {2'b10, 32'h00000000}, {2'b10, 32'h00000000},
                           {2'b00, 32'h00000000}, {2'b00, 32'h00000000},
                           {2'b00, 32'hFFFFFFFF}, {2'b01, 32'h7FFFFFFF},
                           {2'b00, 32'h80000000}, {2'b00, 32'h7FFFFF80}};

  logic [31:0] rf;
  logic [5:0]  rr;
  logic        rm;

  initial begin
    ResetN = 1'b0; InValid = 1'b0; InFloat = '0; InRadixPoint = '0;
    InRoundMode = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge Clock);
    #3;
    check("reset_out_valid", 64'(OutValid), 64'd0);
    check("reset_out_fixed", 64'(OutFixed), 64'd0);
    check("reset_out_overflow", 64'(OutOverflow), 64'd0);
    check("reset_out_exception", 64'(OutException), 64'd0);
    check("reset_in_ready", 64'(InReady), 64'd0);
    ResetN = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < ND; i++) send(d_f[i], d_r[i], d_m[i], d_e[i], 1'b1);
    drain();

    // Backpressure: sink stalls for 5 cycles while 8 beats stream in.
    OutReady = 1'b0;
    saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rf = rand_float();
          rr = 6'($urandom_range(0, 31));
          rm = 1'($urandom_range(0, 1));
          send(rf, rr, rm, model(rf, int'(rr), rm), 1'b0);
        end
      end
      begin
        repeat (5) @(posedge Clock);
        #1;
        OutReady = 1'b1;
      end
    join
    check("bp_in_ready_dropped", 64'(saw_not_ready), 64'd1);
    drain();

    // Reset with three beats in flight.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h3FC00000, 6'd16, 1'b1, {2'b00, 32'h00018000}, 1'b0);
    #1;
    ResetN = 1'b0;
    #1;
    check("midrst_out_valid", 64'(OutValid), 64'd0);
    check("midrst_out_fixed", 64'(OutFixed), 64'd0);
    check("midrst_out_overflow", 64'(OutOverflow), 64'd0);
    check("midrst_out_exception", 64'(OutException), 64'd0);
    check("midrst_in_ready", 64'(InReady), 64'd0);
    exp_q.delete();
    lat_q.delete();
    OutReady = 1'b1;
    repeat (2) @(posedge Clock);
    #3;
    ResetN = 1'b1;
    repeat (12) @(posedge Clock);
    #1;

    // Random traffic with random sink stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge Clock);
            #1;
          end
          rf = rand_float();
          rr = 6'($urandom_range(0, 35));
          rm = 1'($urandom_range(0, 1));
          send(rf, rr, rm, model(rf, int'(rr), rm), 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge Clock);
          #1;
          OutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OutReady = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
